// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - shared instruction/data memory port initiator with fetch/load-store arbitration
module mem_access_ctrl #(
  parameter int MEM_WORDS = 64,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic [31:0]       mem_pc,
  input  logic [DATA_W-1:0] mem_inst,
  output logic [31:0]       mem_rd_addr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  output logic [31:0]       mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t state, next_state;
  logic   prio_if;
  logic   grant_if, grant_ls;
  logic   if_legal, ls_legal;

  assign if_legal = (if_addr[1:0] == 2'b00) && (if_addr < ADDR_LIMIT);
  assign ls_legal = (ls_addr[1:0] == 2'b00) && (ls_addr < ADDR_LIMIT);
  assign if_ready = (state == IDLE) && !rst;
  assign ls_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Single grant per idle edge; prio_if breaks ties and alternates after each grant.
  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    if (state == IDLE) begin
      if (if_req && ls_req) begin
        if (prio_if) grant_if = 1'b1;
        else         grant_ls = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (ls_req) begin
        grant_ls = 1'b1;
      end
      if (grant_if && if_legal)      next_state = FETCH;
      else if (grant_ls && ls_legal) next_state = ls_we ? STORE : LOAD;
    end else begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_if     <= 1'b0;
      if_valid    <= 1'b0;
      if_err      <= 1'b0;
      if_inst     <= '0;
      ls_valid    <= 1'b0;
      ls_err      <= 1'b0;
      ls_rdata    <= '0;
      mem_pc      <= '0;
      mem_rd_addr <= '0;
      mem_we      <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      if_valid <= 1'b0;
      if_err   <= 1'b0;
      ls_valid <= 1'b0;
      ls_err   <= 1'b0;
      mem_we   <= 1'b0;
      if (grant_if) begin
        prio_if <= 1'b0;
        if (if_legal) mem_pc <= if_addr;
        else begin
          if_valid <= 1'b1;
          if_err   <= 1'b1;
        end
      end
      if (grant_ls) begin
        prio_if <= 1'b1;
        if (!ls_legal) begin
          ls_valid <= 1'b1;
          ls_err   <= 1'b1;
        end else if (ls_we) begin
          mem_wr_addr <= ls_addr;
          mem_wr_data <= ls_wdata;
          mem_we      <= 1'b1;
        end else begin
          mem_rd_addr <= ls_addr;
        end
      end
      // Completion: the memory read is combinational, so data is captured at the end of the access cycle.
      case (state)
        FETCH: begin
          if_inst  <= mem_inst;
          if_valid <= 1'b1;
        end
        LOAD: begin
          ls_rdata <= mem_data_out;
          ls_valid <= 1'b1;
        end
        STORE:   ls_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed and randomized checks of mem_access_ctrl against a transaction-level memory model
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_valid, if_err;
  logic [31:0] if_addr, if_inst;
  logic        ls_req, ls_we, ls_ready, ls_valid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mem_pc, mem_inst, mem_rd_addr, mem_data_out, mem_wr_addr, mem_wr_data;
  logic        mem_we;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem      [64];
  logic [31:0] init_mem [64];
  logic [31:0] ref_mem  [64];
  logic        tb_load;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_WORDS(64), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
    .if_inst(if_inst), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd_addr(mem_rd_addr),
    .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  // Memory behind the port: combinational reads, write on the clock edge.
  assign mem_inst     = mem[mem_pc[7:2]];
  assign mem_data_out = mem[mem_rd_addr[7:2]];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (mem_we) begin
      mem[mem_wr_addr[7:2]] <= mem_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 256);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // kind: 0 fetch, 1 load, 2 store. Issued from an idle cycle with a single requester.
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
    bit          legal;
    logic [31:0] exp_data, prev_rdata;
    legal      = is_legal(addr);
    exp_data   = legal ? ref_mem[addr / 4] : 32'h0;
    prev_rdata = ls_rdata;
    chk("ready_before_accept", 32'(kind == 0 ? if_ready : ls_ready), 32'd1);
    if (kind == 0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = (kind == 2); ls_addr = addr; ls_wdata = wdata;
    end
    tick();
    if_req = 1'b0; ls_req = 1'b0;
    if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom; ls_we = 1'($urandom);
    if (!legal) begin
      chk("illegal_valid", 32'(kind == 0 ? if_valid : ls_valid), 32'd1);
      chk("illegal_err",   32'(kind == 0 ? if_err   : ls_err),   32'd1);
      chk("illegal_other_valid", 32'(kind == 0 ? ls_valid : if_valid), 32'd0);
      chk("illegal_no_we", 32'(mem_we), 32'd0);
      chk("illegal_ready", 32'(if_ready), 32'd1);
    end else begin
      chk("busy_no_valid", 32'({if_valid, ls_valid}), 32'd0);
      chk("busy_not_ready", 32'(ls_ready), 32'd0);
      chk("busy_we", 32'(mem_we), 32'(kind == 2));
      if (kind == 2) begin
        chk("store_addr", mem_wr_addr, addr);
        chk("store_data", mem_wr_data, wdata);
      end else if (kind == 1) begin
        chk("load_addr", mem_rd_addr, addr);
      end else begin
        chk("fetch_pc", mem_pc, addr);
      end
      tick();
      chk("done_valid", 32'(kind == 0 ? if_valid : ls_valid), 32'd1);
      chk("done_err",   32'(kind == 0 ? if_err   : ls_err),   32'd0);
      chk("done_we_low", 32'(mem_we), 32'd0);
      if (kind == 0)      chk("fetch_inst", if_inst, exp_data);
      else if (kind == 1) chk("load_rdata", ls_rdata, exp_data);
      else begin
        chk("store_rdata_kept", ls_rdata, prev_rdata);
        ref_mem[addr / 4] = wdata;
      end
    end
  endtask

  // Both requesters held: completions must alternate ls, if, ls, if ...
  task automatic arb(input int n);
    int got   = 0;
    int guard = 0;
    bit exp_ls = 1'b1;
    if_req = 1'b1; if_addr = 32'h8;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
    while (got < n && guard < 4 * n + 4) begin
      tick();
      guard++;
      if (if_valid || ls_valid) begin
        chk("arb_order", 32'({if_valid, ls_valid}), exp_ls ? 32'd1 : 32'd2);
        if (ls_valid) chk("arb_ls_data", ls_rdata, ref_mem[4]);
        if (if_valid) chk("arb_if_data", if_inst, ref_mem[2]);
        got++;
        exp_ls = !exp_ls;
        if (got == n) begin
          if_req = 1'b0; ls_req = 1'b0;
        end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("arb_grants", 32'(got), 32'(n));
  endtask

  initial begin
    int          acc_cyc [3];
    int          val_cyc [3];
    int          n_acc, n_val, r, kind;
    bit          accepting;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[2] = 32'hDEADBEEF;
    ref_mem[2]  = 32'hDEADBEEF;
    rst = 1'b1; tb_load = 1'b1;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    tick(); tick();
    chk("rst_ready", 32'({if_ready, ls_ready}), 32'd0);
    chk("rst_valid", 32'({if_valid, ls_valid, if_err, ls_err}), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_pc", mem_pc, 32'd0);
    chk("rst_rdata", ls_rdata | if_inst, 32'd0);
    rst = 1'b0; tb_load = 1'b0;
    #1;
    chk("ready_after_rst", 32'({if_ready, ls_ready}), 32'd3);

    arb(4);
    access(0, 32'h8, 32'h0);
    access(2, 32'h10, 32'h12345678);
    access(1, 32'h10, 32'h0);
    access(1, 32'h6, 32'h0);
    access(2, 32'h100, 32'hCAFEF00D);
    access(0, 32'hFC, 32'h0);
    access(0, 32'h100, 32'h0);

    // Back-to-back fetches: accept/valid cadence of two cycles.
    n_acc = 0; n_val = 0;
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      accepting = if_ready && if_req;
      tick();
      if (accepting) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 3) if_req = 1'b0;
        else            if_addr = 32'(n_acc * 4);
      end
      if (if_valid && n_val < 3) begin
        chk("b2b_inst", if_inst, ref_mem[n_val]);
        val_cyc[n_val] = c;
        n_val++;
      end
    end
    if_req = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_valids", 32'(n_val), 32'd3);
    if (n_acc == 3 && n_val == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("b2b_accept_cycle", 32'(acc_cyc[k]), 32'(2 * k));
        chk("b2b_valid_cycle", 32'(val_cyc[k]), 32'(2 * k + 1));
      end
    end

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 2));
      r    = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 63)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'h100 + $urandom_range(0, 4096);
      access(kind, a, $urandom);
    end

    // Reset during STORE; write the value already held so memory stays consistent either way.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = ref_mem[8];
    tick();
    ls_req = 1'b0;
    chk("rst_mid_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_we_low", 32'(mem_we), 32'd0);
    chk("rst_mid_valid", 32'({if_valid, ls_valid, if_err, ls_err}), 32'd0);
    chk("rst_mid_outs", mem_pc | mem_rd_addr | mem_wr_addr | mem_wr_data | ls_rdata | if_inst, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_idle", 32'({if_ready, ls_ready}), 32'd3);
    tick();
    chk("rst_mid_no_late_valid", 32'({if_valid, ls_valid, mem_we}), 32'd0);
    arb(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
